// File: rtl/oc8051_bus_sched_pkg.sv
// Shared definitions for the oc8051 dual-core bus scheduler: holder encodings,
// scheduler state encoding and the burst-quota helper.
package oc8051_defines;

  localparam logic PROC_A = 1'b1;
  localparam logic PROC_B = 1'b0;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_BUSY = 2'd1,
    SCHED_DENY = 2'd2
  } sched_state_e;

  // Consecutive-grant count: restarts at 1 on a holder change, saturates at quota.
  function automatic logic [3:0] burst_next(input logic [3:0] cnt,
                                            input logic [3:0] quota,
                                            input logic       same);
    if (!same)         return 4'd1;
    if (cnt >= quota)  return quota;
    return cnt + 4'd1;
  endfunction

endpackage

// File: rtl/oc8051_bus_wdog.sv
// Transaction watchdog: counts cycles while enabled, clears on request and
// flags the terminal count TIMEOUT-1.
module oc8051_bus_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 8'd1;
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/oc8051_bus_sched.sv
// Registered one-transaction-at-a-time scheduler for the bus shared by two oc8051
// cores, with burst quota and watchdog abort. Optional OC8051_BUS_PRIV_FILTER_EN.
module oc8051_bus_sched
  import oc8051_defines::*;
#(
  parameter int          QUOTA   = 4,
  parameter int          TIMEOUT = 64,
  parameter logic [15:0] PROT_LO = 16'hF000,
  parameter logic [15:0] PROT_HI = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb_A,
  input  logic        stb_B,
  input  logic        wr_A,
  input  logic        wr_B,
  input  logic [15:0] addr_A,
  input  logic [15:0] addr_B,
  input  logic [7:0]  data_in_A,
  input  logic [7:0]  data_in_B,
  input  logic        priv_lvl_A,
  input  logic        priv_lvl_B,
  output logic        ack_A,
  output logic        ack_B,
  output logic        err_A,
  output logic        err_B,
  output logic [7:0]  data_out_A,
  output logic [7:0]  data_out_B,
  output logic        stb,
  output logic        wr,
  output logic [15:0] addr,
  output logic [7:0]  data_in,
  output logic        priv_lvl,
  input  logic        ack,
  input  logic [7:0]  data_out,
  output logic        selected_proc,
  output logic        timeout
);

  localparam logic [3:0] QUOTA_C = 4'(QUOTA);

  sched_state_e state_q, state_d;
  logic         sel_q, sel_d;
  logic [3:0]   burst_q, burst_d;
  logic         win, deny;
  logic         wd_clr, wd_en, wd_tc;
  logic         hold_ack, hold_err;

  // Fair pick: the holder keeps the bus only while under quota and contended.
  always_comb begin
    win = stb_A ? PROC_A : PROC_B;
    if (stb_A && stb_B) win = (burst_q < QUOTA_C) ? sel_q : ~sel_q;
  end

`ifdef OC8051_BUS_PRIV_FILTER_EN
  logic        w_priv;
  logic [15:0] w_addr;
  assign w_priv = (win == PROC_A) ? priv_lvl_A : priv_lvl_B;
  assign w_addr = (win == PROC_A) ? addr_A : addr_B;
  assign deny   = !w_priv && ({1'b0, w_addr} >= {1'b0, PROT_LO})
                          && ({1'b0, w_addr} <= {1'b0, PROT_HI});
`else
  logic unused_prot;
  assign unused_prot = ^{PROT_LO, PROT_HI};
  assign deny        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    burst_d  = burst_q;
    stb      = 1'b0;
    hold_ack = 1'b0;
    hold_err = 1'b0;
    timeout  = 1'b0;
    wd_clr   = 1'b1;
    wd_en    = 1'b0;
    case (state_q)
      SCHED_IDLE: begin
        if (stb_A || stb_B) begin
          sel_d   = win;
          burst_d = burst_next(burst_q, QUOTA_C, win == sel_q);
          state_d = deny ? SCHED_DENY : SCHED_BUSY;
        end
      end
      SCHED_BUSY: begin
        wd_clr   = 1'b0;
        wd_en    = 1'b1;
        hold_ack = ack;
        // A late ack still completes the transfer; the abort only fires without it.
        stb      = ((sel_q == PROC_A) ? stb_A : stb_B) && !(wd_tc && !ack);
        if (ack) begin
          state_d = SCHED_IDLE;
        end else if (wd_tc) begin
          timeout  = 1'b1;
          hold_err = 1'b1;
          state_d  = SCHED_IDLE;
        end
      end
      SCHED_DENY: begin
        hold_err = 1'b1;
        state_d  = SCHED_IDLE;
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCHED_IDLE;
      sel_q   <= PROC_A;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      burst_q <= burst_d;
    end
  end

  oc8051_bus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tc_o  (wd_tc)
  );

  assign wr            = (sel_q == PROC_A) ? wr_A       : wr_B;
  assign addr          = (sel_q == PROC_A) ? addr_A     : addr_B;
  assign data_in       = (sel_q == PROC_A) ? data_in_A  : data_in_B;
  assign priv_lvl      = (sel_q == PROC_A) ? priv_lvl_A : priv_lvl_B;
  assign ack_A         = hold_ack && (sel_q == PROC_A);
  assign ack_B         = hold_ack && (sel_q == PROC_B);
  assign err_A         = hold_err && (sel_q == PROC_A);
  assign err_B         = hold_err && (sel_q == PROC_B);
  assign data_out_A    = data_out;
  assign data_out_B    = data_out;
  assign selected_proc = sel_q;

endmodule

// File: tb/tb_oc8051_bus_sched.sv
// Directed bench for oc8051_bus_sched: inputs change 1 ns after posedge, outputs
// are checked at negedge; completed transfers are matched against a scoreboard.
module tb_oc8051_bus_sched;

  localparam int QUOTA   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb_A, stb_B, wr_A, wr_B, priv_lvl_A, priv_lvl_B;
  logic [15:0] addr_A, addr_B;
  logic [7:0]  data_in_A, data_in_B;
  logic        ack_A, ack_B, err_A, err_B;
  logic [7:0]  data_out_A, data_out_B;
  logic        stb, wr, priv_lvl, ack, selected_proc, timeout;
  logic [15:0] addr;
  logic [7:0]  data_in, data_out;

  always #5 clk = ~clk;

  oc8051_bus_sched #(.QUOTA(QUOTA), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .stb_A(stb_A), .stb_B(stb_B), .wr_A(wr_A), .wr_B(wr_B),
    .addr_A(addr_A), .addr_B(addr_B), .data_in_A(data_in_A), .data_in_B(data_in_B),
    .priv_lvl_A(priv_lvl_A), .priv_lvl_B(priv_lvl_B),
    .ack_A(ack_A), .ack_B(ack_B), .err_A(err_A), .err_B(err_B),
    .data_out_A(data_out_A), .data_out_B(data_out_B),
    .stb(stb), .wr(wr), .addr(addr), .data_in(data_in), .priv_lvl(priv_lvl),
    .ack(ack), .data_out(data_out), .selected_proc(selected_proc), .timeout(timeout)
  );

  typedef struct {
    logic        sel;
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic s, input logic [15:0] a, input logic w,
                      input logic [7:0] wd, input logic [7:0] rd);
    exp_t e;
    e.sel = s; e.addr = a; e.wr = w; e.wdata = wd; e.rdata = rd;
    sb.push_back(e);
  endtask

  // Downstream acks the current transfer this cycle; compare against oldest entry.
  task automatic sb_ack();
    exp_t e;
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() == 0) begin
      next_cycle();
      return;
    end
    e = sb.pop_front();
    ack = 1'b1;
    data_out = e.rdata;
    mid();
    chk("sb_sel",   selected_proc, e.sel);
    chk("sb_stb",   stb, 1);
    chk("sb_addr",  addr, e.addr);
    chk("sb_wr",    wr, e.wr);
    chk("sb_wdata", data_in, e.wdata);
    chk("sb_ackA",  ack_A, e.sel);
    chk("sb_ackB",  ack_B, !e.sel);
    chk("sb_rdata", e.sel ? data_out_A : data_out_B, e.rdata);
    chk("sb_errs",  {err_A, err_B, timeout}, 0);
    next_cycle();
    ack = 1'b0;
    data_out = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stb_A = 0; stb_B = 0; wr_A = 0; wr_B = 0; ack = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0]  seq;
    logic [15:0] a_addr, b_addr;
    exp_t        e;

    rst = 1'b0;
    stb_A = 0; stb_B = 0; wr_A = 0; wr_B = 0; ack = 0; data_out = 8'h00;
    addr_A = 16'h0; addr_B = 16'h0; data_in_A = 8'h0; data_in_B = 8'h0;
    priv_lvl_A = 1'b1; priv_lvl_B = 1'b1;
    #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_stb", stb, 0);
    chk("rst_acks", {ack_A, ack_B}, 0);
    chk("rst_errs", {err_A, err_B}, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_sel", selected_proc, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request from A, ack in cycle 3, then B in the IDLE gap.
    stb_A = 1; wr_A = 0; addr_A = 16'h1234; data_in_A = 8'h11; priv_lvl_A = 1;
    push(1'b1, 16'h1234, 1'b0, 8'h11, 8'h5A);
    mid(); chk("t1_c0_stb", stb, 0); next_cycle();
    mid(); chk("t1_c1_stb", stb, 1); chk("t1_c1_addr", addr, 16'h1234);
    chk("t1_c1_sel", selected_proc, 1); chk("t1_c1_priv", priv_lvl, 1); next_cycle();
    mid(); chk("t1_c2_stb", stb, 1); chk("t1_c2_ackA", ack_A, 0); next_cycle();
    sb_ack();
    stb_A = 0; stb_B = 1; wr_B = 1; addr_B = 16'h5678; data_in_B = 8'h77; priv_lvl_B = 0;
    push(1'b0, 16'h5678, 1'b1, 8'h77, 8'h00);
    mid(); chk("t1_c4_stb", stb, 0); chk("t1_c4_ackA", ack_A, 0); next_cycle();
    mid(); chk("t1_c5_stb", stb, 1); chk("t1_c5_sel", selected_proc, 0);
    chk("t1_c5_priv", priv_lvl, 0); next_cycle();
    sb_ack();
    stb_B = 0; wr_B = 0;

    // Quota: both cores request continuously, ack one cycle after stb.
    do_reset();
    seq = 10'b1111_0000_11;
    a_addr = 16'hA000; b_addr = 16'hB000;
    data_in_A = 8'hAA; data_in_B = 8'hBB; priv_lvl_A = 1; priv_lvl_B = 1;
    for (int i = 0; i < 10; i++) begin
      stb_A = 1; stb_B = 1; addr_A = a_addr; addr_B = b_addr;
      e.sel = seq[9-i];
      push(e.sel, e.sel ? a_addr : b_addr, 1'b0, e.sel ? 8'hAA : 8'hBB, 8'(8'h40 + i));
      mid(); chk("q_idle_stb", stb, 0); next_cycle();
      mid(); chk("q_busy_stb", stb, 1); chk("q_grant", selected_proc, e.sel); next_cycle();
      sb_ack();
      if (e.sel) a_addr = a_addr + 16'd1;
      else       b_addr = b_addr + 16'd1;
    end
    stb_A = 0; stb_B = 0;

    // Timeout: B never acked, abort on the 8th BUSY cycle.
    do_reset();
    stb_B = 1; addr_B = 16'h2222; data_in_B = 8'h22;
    mid(); chk("to_c0_stb", stb, 0); next_cycle();
    for (int c = 1; c < TIMEOUT; c++) begin
      mid();
      chk("to_busy_stb", stb, 1);
      chk("to_busy_err", {err_B, timeout}, 0);
      next_cycle();
    end
    mid();
    chk("to_errB", err_B, 1); chk("to_pulse", timeout, 1);
    chk("to_stb", stb, 0); chk("to_errA", err_A, 0); chk("to_ackB", ack_B, 0);
    next_cycle();
    stb_B = 0; stb_A = 1; addr_A = 16'h0ABC; data_in_A = 8'h3C; priv_lvl_A = 1;
    push(1'b1, 16'h0ABC, 1'b0, 8'h3C, 8'hC3);
    mid(); chk("to_idle_stb", stb, 0); chk("to_idle_err", {err_B, timeout}, 0); next_cycle();
    mid(); chk("to_after_stb", stb, 1); chk("to_after_sel", selected_proc, 1); next_cycle();
    sb_ack();
    stb_A = 0;

    // Ack on the terminal-count cycle: ack wins.
    stb_B = 1; addr_B = 16'h3333; data_in_B = 8'h33;
    push(1'b0, 16'h3333, 1'b0, 8'h33, 8'h99);
    mid(); chk("col_c0_stb", stb, 0); next_cycle();
    for (int c = 1; c < TIMEOUT; c++) begin
      mid(); chk("col_busy_stb", stb, 1); chk("col_busy_to", timeout, 0); next_cycle();
    end
    sb_ack();
    stb_B = 0;
    mid(); chk("col_idle_stb", stb, 0); chk("col_idle_err", {err_B, timeout}, 0); next_cycle();

    // Asynchronous reset in the middle of a BUSY cycle.
    stb_B = 1; addr_B = 16'h4444;
    mid(); chk("ar_c0_stb", stb, 0); next_cycle();
    mid(); chk("ar_c1_stb", stb, 1); chk("ar_c1_sel", selected_proc, 0); next_cycle();
    ack = 1'b1;
    #2;
    chk("ar_pre_ackB", ack_B, 1);
    rst = 1'b1;
    #1;
    chk("ar_stb", stb, 0); chk("ar_ackB", ack_B, 0); chk("ar_errB", err_B, 0);
    chk("ar_timeout", timeout, 0); chk("ar_sel", selected_proc, 1);
    stb_B = 0; ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    mid(); chk("ar_post_stb", stb, 0); next_cycle();

    // Unprivileged access to the protected window.
    stb_A = 1; wr_A = 0; addr_A = 16'hF800; data_in_A = 8'h5F; priv_lvl_A = 0;
`ifdef OC8051_BUS_PRIV_FILTER_EN
    mid(); chk("pf_c0_stb", stb, 0); next_cycle();
    mid(); chk("pf_deny_stb", stb, 0); chk("pf_deny_errA", err_A, 1);
    chk("pf_deny_sel", selected_proc, 1); chk("pf_deny_to", timeout, 0); next_cycle();
    stb_A = 0;
    mid(); chk("pf_after_stb", stb, 0); chk("pf_after_errA", err_A, 0); next_cycle();
    stb_A = 1; priv_lvl_A = 1;
    push(1'b1, 16'hF800, 1'b0, 8'h5F, 8'hE1);
    mid(); chk("pp_c0_stb", stb, 0); next_cycle();
    mid(); chk("pp_stb", stb, 1); chk("pp_priv", priv_lvl, 1); chk("pp_errA", err_A, 0); next_cycle();
    sb_ack();
`else
    push(1'b1, 16'hF800, 1'b0, 8'h5F, 8'hE1);
    mid(); chk("pf_c0_stb", stb, 0); next_cycle();
    mid(); chk("pf_stb", stb, 1); chk("pf_priv", priv_lvl, 0); chk("pf_errA", err_A, 0); next_cycle();
    sb_ack();
`endif
    stb_A = 0;
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
